// File: rtl/adc16dv160_capture_packer.sv
// Packs pairs of 16-bit ADC samples into 32-bit AXI-Stream words, one DSIZE-byte packet per start.
// A word FIFO plus an output register decouple the sample stream from downstream tready stalls.
module adc16dv160_capture_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int DSIZE_W    = 32
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               sample_valid,
    input  logic [15:0]        sample,
    input  logic               start,
    input  logic               test,
    input  logic [DSIZE_W-1:0] dsize,
    output logic               busy,
    output logic               pc,
    output logic               overflow,
    output logic               m_axis_tvalid,
    output logic [31:0]        m_axis_tdata,
    output logic [3:0]         m_axis_tkeep,
    output logic               m_axis_tlast,
    input  logic               m_axis_tready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [DSIZE_W-1:0] r_numWords;
    logic [DSIZE_W-1:0] r_wordCnt;
    logic               r_test;
    logic               r_phase;
    logic [15:0]        r_testCnt;
    logic [15:0]        r_hold;
    logic               r_pc;
    logic               r_overflow;

    logic [32:0]        r_mem [FIFO_DEPTH];
    logic [AW:0]        r_wrPtr;
    logic [AW:0]        r_rdPtr;

    logic               r_outValid;
    logic               r_outLast;
    logic [31:0]        r_outData;

    logic [DSIZE_W-1:0] w_reqWords;
    logic               w_startOk;
    logic [15:0]        w_sample;
    logic               w_capSample;
    logic               w_wrReq;
    logic [AW:0]        w_fifoCount;
    logic               w_fifoEmpty;
    logic               w_fifoFull;
    logic               w_fifoRd;
    logic               w_wrOk;
    logic               w_wrDrop;
    logic               w_isLastWord;
    logic               w_lastBeat;
    logic [32:0]        w_wrWord;
    logic [32:0]        w_rdWord;

    assign w_reqWords   = dsize >> 2;
    assign w_startOk    = start && (r_state == IDLE) && (w_reqWords != '0);
    assign w_sample     = r_test ? r_testCnt : sample;
    assign w_capSample  = (r_state == CAPTURE) && sample_valid;
    assign w_wrReq      = w_capSample && r_phase;

    assign w_fifoCount  = r_wrPtr - r_rdPtr;
    assign w_fifoEmpty  = (w_fifoCount == '0);
    assign w_fifoFull   = (w_fifoCount == FULL_COUNT);
    assign w_fifoRd     = !w_fifoEmpty && (!r_outValid || m_axis_tready);
    // A read in the same cycle frees a slot, so a full FIFO can still accept the write
    assign w_wrOk       = w_wrReq && (!w_fifoFull || w_fifoRd);
    assign w_wrDrop     = w_wrReq && !w_wrOk;

    assign w_isLastWord = (r_wordCnt == (r_numWords - DSIZE_W'(1)));
    assign w_lastBeat   = r_outValid && m_axis_tready && r_outLast;
    assign w_wrWord     = {w_isLastWord, w_sample, r_hold};
    assign w_rdWord     = r_mem[r_rdPtr[AW-1:0]];

    assign busy          = (r_state != IDLE);
    assign pc            = r_pc;
    assign overflow      = r_overflow;
    assign m_axis_tvalid = r_outValid;
    assign m_axis_tdata  = r_outData;
    assign m_axis_tkeep  = 4'hF;
    assign m_axis_tlast  = r_outLast;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_startOk) begin
                    w_nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_wrOk && w_isLastWord) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (w_lastBeat) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_numWords <= '0;
            r_wordCnt  <= '0;
            r_test     <= 1'b0;
            r_phase    <= 1'b0;
            r_testCnt  <= '0;
            r_hold     <= '0;
            r_pc       <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_startOk) begin
            r_numWords <= w_reqWords;
            r_test     <= test;
            r_wordCnt  <= '0;
            r_phase    <= 1'b0;
            r_testCnt  <= '0;
            r_pc       <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_capSample) begin
                r_phase   <= ~r_phase;
                r_testCnt <= r_testCnt + 16'd1;
                if (!r_phase) begin
                    r_hold <= w_sample;
                end
            end
            // A dropped word does not advance the count, so the packet still ends with N words
            if (w_wrOk) begin
                r_wordCnt <= r_wordCnt + DSIZE_W'(1);
            end
            if (w_wrDrop) begin
                r_overflow <= 1'b1;
            end
            if (w_lastBeat) begin
                r_pc <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_wrOk) begin
            r_mem[r_wrPtr[AW-1:0]] <= w_wrWord;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_wrOk) begin
                r_wrPtr <= r_wrPtr + (AW+1)'(1);
            end
            if (w_fifoRd) begin
                r_rdPtr <= r_rdPtr + (AW+1)'(1);
            end
        end
    end

    // Output register keeps tvalid independent of tready and holds data through stalls
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outData  <= '0;
        end else if (w_fifoRd) begin
            r_outValid <= 1'b1;
            r_outLast  <= w_rdWord[32];
            r_outData  <= w_rdWord[31:0];
        end else if (m_axis_tready) begin
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc16dv160_capture_packer.sv
// Randomised bench for the capture packer: a packet-level model predicts the words from the
// samples seen during capture, and every delivered AXI-Stream beat is compared against it.
module tb_adc16dv160_capture_packer;

    localparam int BUDGET = 30000;

    logic        clk = 1'b0;
    logic        ARESET = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample = '0;
    logic        start = 1'b0;
    logic        test = 1'b0;
    logic [31:0] dsize = '0;
    logic        busy;
    logic        pc;
    logic        overflow;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b0;

    int checks = 0;
    int errors = 0;

    bit          mBusy = 1'b0;
    bit          mCapturing = 1'b0;
    bit          mTest = 1'b0;
    bit          mPc = 1'b0;
    int          mN = 0;
    int          mSampCnt = 0;
    logic [15:0] mCnt = '0;
    logic [15:0] mLow = '0;
    logic [32:0] expQ[$];
    logic [32:0] obsQ[$];
    bit          prevStall = 1'b0;
    logic [32:0] prevWord = '0;

    adc16dv160_capture_packer #(
        .FIFO_DEPTH(4),
        .DSIZE_W(32)
    ) dut (
        .ACLK(clk),
        .ARESET(ARESET),
        .sample_valid(sample_valid),
        .sample(sample),
        .start(start),
        .test(test),
        .dsize(dsize),
        .busy(busy),
        .pc(pc),
        .overflow(overflow),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Packet-level reference: pairs of captured samples become words, last one flagged
    task automatic modelCycle();
        logic [15:0] v;
        if (ARESET) begin
            mBusy = 1'b0;
            mCapturing = 1'b0;
            mPc = 1'b0;
            expQ.delete();
            obsQ.delete();
            return;
        end
        if (mCapturing && sample_valid) begin
            v = mTest ? mCnt : sample;
            mCnt = mCnt + 16'd1;
            if (mSampCnt % 2 == 0) begin
                mLow = v;
            end else begin
                expQ.push_back({(mSampCnt / 2 == mN - 1), v, mLow});
            end
            mSampCnt++;
            if (mSampCnt == 2 * mN) mCapturing = 1'b0;
        end
        if (!mBusy && start && (dsize >> 2) != 0) begin
            mBusy = 1'b1;
            mCapturing = 1'b1;
            mTest = test;
            mN = int'(dsize >> 2);
            mSampCnt = 0;
            mCnt = '0;
            mPc = 1'b0;
            expQ.delete();
            obsQ.delete();
        end
    endtask

    task automatic monitorCycle();
        if (ARESET) begin
            prevStall = 1'b0;
            return;
        end
        if (prevStall) begin
            checkOutput("stallHold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prevWord});
        end
        if (m_axis_tvalid && m_axis_tready) begin
            checkOutput("tkeep", m_axis_tkeep, 4'hF);
            obsQ.push_back({m_axis_tlast, m_axis_tdata});
            if (m_axis_tlast) begin
                mBusy = 1'b0;
                mPc = 1'b1;
            end
        end
        prevStall = m_axis_tvalid && !m_axis_tready;
        prevWord = {m_axis_tlast, m_axis_tdata};
    endtask

    // Drives one cycle of inputs just after the rising edge and returns at the falling edge
    task automatic applyStimulus(input logic sv, input logic [15:0] smp, input logic st,
                                 input logic tr, input logic rst);
        @(posedge clk);
        #1;
        sample_valid = sv;
        sample = smp;
        start = st;
        m_axis_tready = tr;
        ARESET = rst;
        modelCycle();
        @(negedge clk);
        monitorCycle();
    endtask

    task automatic startPacket(input int dsz, input bit tst);
        dsize = dsz;
        test = tst;
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic drivePacket(input int svPct, input int trPct, input int stall, input int midStartAt);
        int cyc;
        logic sv, st, tr;
        cyc = 0;
        while (mBusy && cyc < BUDGET) begin
            sv = ($urandom_range(99) < svPct);
            tr = (cyc < stall) ? 1'b0 : ($urandom_range(99) < trPct);
            st = (cyc == midStartAt);
            if (st) dsize = 8;
            applyStimulus(sv, 16'($urandom), st, tr, 1'b0);
            cyc++;
        end
        if (mBusy) begin
            checkOutput("timeout", 1, 0);
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("busyDone", busy, 0);
        checkOutput("pcDone", pc, mPc);
        checkOutput("tvalidIdle", m_axis_tvalid, 0);
    endtask

    task automatic compareQueues(input string tag);
        int n;
        checkOutput({tag, "Count"}, obsQ.size(), expQ.size());
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "Word"}, obsQ[i], expQ[i]);
        end
    endtask

    initial begin
        logic [15:0] lo, prevLo;
        int wait_cnt;

        // Reset state
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstPc", pc, 0);
        checkOutput("rstOvf", overflow, 0);
        checkOutput("rstTvalid", m_axis_tvalid, 0);
        checkOutput("rstTlast", m_axis_tlast, 0);

        // Counter pattern, full rate; a start mid-capture must not change the packet
        $display("[TB] test pattern 16 bytes");
        startPacket(16, 1'b1);
        drivePacket(100, 100, 0, 3);
        compareQueues("t1");
        for (int i = 0; i < 4 && i < obsQ.size(); i++) begin
            checkOutput("t1Const", obsQ[i][31:0], {16'(2 * i + 1), 16'(2 * i)});
        end

        // Directed samples, also checks the two-cycle latency to tvalid
        $display("[TB] directed samples 8 bytes");
        startPacket(8, 1'b0);
        applyStimulus(1'b1, 16'h1111, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h2222, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h3333, 1'b0, 1'b1, 1'b0);
        checkOutput("latEarly", m_axis_tvalid, 0);
        applyStimulus(1'b1, 16'h4444, 1'b0, 1'b1, 1'b0);
        checkOutput("latValid", m_axis_tvalid, 1);
        checkOutput("t2Word0", m_axis_tdata, 32'h22221111);
        checkOutput("t2Keep", m_axis_tkeep, 4'hF);
        checkOutput("t2Last0", m_axis_tlast, 0);
        drivePacket(0, 100, 0, -1);
        compareQueues("t2");

        // Long stall overflows the small FIFO; packet still ends with 16 words
        $display("[TB] overflow under stall");
        startPacket(64, 1'b1);
        drivePacket(100, 100, 20, -1);
        checkOutput("ovfFlag", overflow, 1);
        checkOutput("ovfCount", obsQ.size(), 16);
        prevLo = '0;
        for (int i = 0; i < obsQ.size(); i++) begin
            lo = obsQ[i][15:0];
            checkOutput("ovfLast", obsQ[i][32], (i == 15));
            checkOutput("ovfPair", obsQ[i][31:16], lo + 16'd1);
            checkOutput("ovfEven", lo[0], 0);
            if (i > 0) checkOutput("ovfOrder", (lo > prevLo), 1);
            prevLo = lo;
        end

        // Zero-word start is ignored and leaves pc alone
        $display("[TB] zero-word start");
        dsize = 3;
        applyStimulus(1'b1, 16'($urandom), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b1, 1'b0);
            checkOutput("ignTvalid", m_axis_tvalid, 0);
        end
        checkOutput("ignBusy", busy, 0);
        checkOutput("ignPc", pc, mPc);

        // Reset in the middle of a packet, then a fresh packet restarts the counter
        $display("[TB] mid-packet reset");
        startPacket(32, 1'b1);
        wait_cnt = 0;
        while (obsQ.size() < 2 && wait_cnt < 100) begin
            applyStimulus(1'b1, '0, 1'b0, 1'b1, 1'b0);
            wait_cnt++;
        end
        checkOutput("rstMidReached", (obsQ.size() >= 2), 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("midTvalid", m_axis_tvalid, 0);
        checkOutput("midTlast", m_axis_tlast, 0);
        checkOutput("midTdata", m_axis_tdata, 0);
        checkOutput("midBusy", busy, 0);
        checkOutput("midPc", pc, 0);
        checkOutput("midOvf", overflow, 0);
        startPacket(8, 1'b1);
        drivePacket(100, 100, 0, -1);
        compareQueues("t5");
        if (obsQ.size() > 0) checkOutput("t5Restart", obsQ[0], {1'b0, 32'h00010000});

        // Random sample data, random tready
        $display("[TB] random data packet");
        startPacket(4 * $urandom_range(50, 1), 1'b0);
        drivePacket(50, 70, 0, -1);
        compareQueues("rnd");
        checkOutput("rndOvf", overflow, 0);

        // Large packets with random tready, run twice back to back
        for (int r = 0; r < 2; r++) begin
            $display("[TB] large packet run %0d", r);
            startPacket(4096, 1'b1);
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
            checkOutput("bigPcClear", pc, 0);
            checkOutput("bigBusy", busy, 1);
            drivePacket(20, 50, 0, -1);
            compareQueues("big");
            checkOutput("bigOvf", overflow, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
